muldiv_unit_nbit: RTL and testbench
===================================

# muldiv_unit_nbit

Iterative RV32M multiply/divide unit attached to the EX stage of the pipelined core, generalised to an XLEN-wide datapath. It accepts one M-extension operation per start pulse, runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, and returns the result with a single-cycle done pulse. The hazard logic uses busy to stall IF/ID/EX and flush to kill an in-flight operation on branch redirect.

## Interface
- XLEN, 32: operand/result width; even, ≥ 4.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- flush  in  1  abort the in-flight operation.
- funct3  in  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (multiplicand/dividend).
- op_b  in  XLEN  rs2 value (multiplier/divisor).
- busy  out  1  high in CALC and FIXUP.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE + start=1: latch funct3, operand magnitudes and result sign; counter←0; go to CALC. Special cases go to DONE directly instead.
- DONE without start: go to IDLE.
- Signedness:
  - op_a is signed for MULH, MULHSU, DIV, REM.
  - op_b is signed for MULH, DIV, REM.
  - MUL is sign-agnostic (low half).
- Multiply: 2·XLEN accumulator, one shift-add per CALC cycle. MUL takes the low half; MULH/MULHSU/MULHU take the high half after sign correction of the full 2·XLEN product.
- Divide: restoring, one quotient bit per CALC cycle.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- CALC runs exactly XLEN cycles (counter 0..XLEN-1), then FIXUP.
- FIXUP applies two's-complement negation where required, loads result, and goes to DONE.
- Special cases (no CALC):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (op_a = 1 followed by XLEN-1 zeros, op_b = all-ones): DIV gives op_a; REM gives 0.
- start while busy is ignored (no queueing).
- flush=1 in any state: go to IDLE; done is not asserted; result is unchanged. In IDLE/DONE, flush has priority over a simultaneous start.
- rst=0: state IDLE; busy=0, done=0, result=0, counter=0, accumulators=0. Applies mid-operation.

## Timing
- Start sampled at the end of cycle 0.
- Normal ops: busy=1 in cycles 1..XLEN+1; done=1 in cycle XLEN+2 (34 for XLEN=32).
- Special cases: done=1 in cycle 1; busy stays 0.
- Back-to-back: start asserted in the DONE cycle is accepted, giving zero idle cycles between operations.
- flush sampled in cycle k: busy=0 and done=0 from cycle k+1.
- rst sampled low: all outputs at reset values in the next cycle.
- done and result are registered; no combinational path from inputs to outputs.

## Structure
- Shared package muldiv_pkg:
  - funct3 encoding constants.
  - State enum.
  - OPCODE_OP / funct7 = 0000001 constant for decode elsewhere.
- Counter width: $clog2(XLEN)+1.
- One sub-module, twos_negate_nbit #(W): combinational negation, instantiated at XLEN for divide fixup and at 2·XLEN for multiply fixup.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; busy high in cycles 1–33; done in cycle 34.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; back-to-back starts issued in the DONE cycles.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done in cycle 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- DIVU start; second start at cycle 5 ignored; flush at cycle 10 → busy=0 in cycle 11, no done, result keeps its prior value.
- rst=0 at cycle 15 of MUL → busy/done/result = 0 next cycle; new MULU-style MULHU 3×3 afterward → 0, done on schedule.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M-style multiply/divide unit: funct3 encodings,
// the FSM state type and small decode helpers.
package muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_nbit_if.sv
// Request/response bundle between the EX stage (master) and the muldiv unit (slave).
interface muldiv_unit_nbit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/twos_negate_nbit.sv
// Combinational two's-complement negation of a W-bit value.
module twos_negate_nbit #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    output logic [W-1:0] out_val
);
    assign out_val = ~in_val + W'(1);
endmodule

// File: rtl/muldiv_unit_nbit.sv
// Iterative XLEN-wide multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied once in FIXUP.
module muldiv_unit_nbit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    muldiv_unit_nbit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_neg, prod_fix;
    logic [XLEN-1:0]   div_sel, div_neg, div_fix;
    logic              div_sel_neg;

    assign accept   = bus.start && !bus.flush && (state_q == ST_IDLE || state_q == ST_DONE);
    assign a_neg    = op_a_signed(bus.funct3) && bus.op_a[XLEN-1];
    assign b_neg    = op_b_signed(bus.funct3) && bus.op_b[XLEN-1];
    assign mag_a    = a_neg ? -bus.op_a : bus.op_a;
    assign mag_b    = b_neg ? -bus.op_b : bus.op_b;
    assign div_zero = is_div(bus.funct3) && (bus.op_b == {XLEN{1'b0}});
    assign div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                      (bus.op_a == INT_MIN) && (bus.op_b == {XLEN{1'b1}});

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge   = (div_part >= {1'b0, opnd_q});
    assign div_diff = div_part[XLEN-1:0] - opnd_q;

    assign div_sel     = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_sel_neg = funct3_q[1] ? a_neg_q : (a_neg_q ^ b_neg_q);
    assign div_fix     = div_sel_neg ? div_neg : div_sel;
    assign prod_fix    = (a_neg_q ^ b_neg_q) ? prod_neg : acc_q;

    twos_negate_nbit #(.W(2*XLEN)) u_neg_prod (.in_val(acc_q),   .out_val(prod_neg));
    twos_negate_nbit #(.W(XLEN))   u_neg_div  (.in_val(div_sel), .out_val(div_neg));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        funct3_d = funct3_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                if (accept) begin
                    funct3_d = bus.funct3;
                    cnt_d    = '0;
                    a_neg_d  = a_neg;
                    b_neg_d  = b_neg;
                    if (div_zero) begin
                        result_d = is_rem(bus.funct3) ? bus.op_a : {XLEN{1'b1}};
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else if (div_ovf) begin
                        result_d = is_rem(bus.funct3) ? {XLEN{1'b0}} : bus.op_a;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, (is_div(bus.funct3) ? mag_a : mag_b)};
                        opnd_d  = is_div(bus.funct3) ? mag_b : mag_a;
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div(funct3_q)) begin
                    acc_d = {(div_ge ? div_diff : div_part[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                if (is_div(funct3_q)) begin
                    result_d = div_fix;
                end else if (funct3_q == F3_MUL) begin
                    result_d = prod_fix[XLEN-1:0];
                end else begin
                    result_d = prod_fix[2*XLEN-1:XLEN];
                end
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Flush wins over everything, including a start arriving in IDLE/DONE.
        if (bus.flush) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            funct3_q <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            funct3_q <= funct3_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit_nbit.sv
// Self-checking bench for muldiv_unit_nbit: directed vector table, randomized ops against
// a wide-integer reference model, and start-ignore / flush / reset sequences.
module tb_muldiv_unit_nbit;
    localparam int XLEN  = 32;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_nbit_if #(.XLEN(XLEN)) bus();
    muldiv_unit_nbit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain 64-bit integer arithmetic following the RV32M result rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'(signed'(a));
        longint          sb = longint'(signed'(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        case (f3)
            3'b000: begin p = ua * ub;           return p[31:0];  end
            3'b001: begin p = sa * sb;           return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub;           return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return !f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF;
    endfunction

    // Issues one op in the current cycle and follows it to done; poke>0 injects a stray start at that cycle.
    task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int poke);
        int cyc;
        int busy_cnt;
        bit special;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!bus.done && cyc < LIMIT) begin
            if (bus.busy) busy_cnt++;
            if (cyc == poke) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'b000;
                bus.op_a   = 32'd3;
                bus.op_b   = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        special = is_special(f3, a, b);
        checkOutput({name, " done cycle"}, 64'(cyc), special ? 64'd1 : 64'(XLEN + 2));
        checkOutput({name, " busy cycles"}, 64'(busy_cnt), special ? 64'd0 : 64'(XLEN + 1));
        checkOutput({name, " busy at done"}, 64'(bus.busy), 64'd0);
        checkOutput({name, " result"}, 64'(bus.result), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rexp;
        logic [2:0]  rf3;
        int          done_seen;

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) tick();
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset result", 64'(bus.result), 64'd0);
        rst = 1'b1;
        tick();

        vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14});
        vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2});
        vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF});
        vecs.push_back('{3'b110, 32'd5,        32'd0,        32'd5});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{3'b101, 32'd9,        32'd0,        32'hFFFFFFFF});
        vecs.push_back('{3'b111, 32'd9,        32'd0,        32'd9});

        // Consecutive calls start each op in the previous op's DONE cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
        end
        tick();
        checkOutput("hold done low", 64'(bus.done), 64'd0);
        checkOutput("hold result", 64'(bus.result), 64'(vecs[vecs.size()-1].exp));

        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'h80000000;
                2: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rexp = ref_model(rf3, ra, rb);
            applyStimulus($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf3, ra, rb), rf3, ra, rb, rexp, 0);
        end

        applyStimulus("divu stray start", 3'b101, 32'd100, 32'd7, 32'd14, 5);

        applyStimulus("mul before flush", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        bus.funct3 = 3'b101;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        bus.start  = 1'b1;
        tick();
        for (int c = 1; c < 10; c++) begin
            bus.start = (c == 5);
            if (c == 5) begin
                bus.funct3 = 3'b000;
                bus.op_a   = 32'd3;
                bus.op_b   = 32'd3;
            end
            tick();
        end
        bus.start = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("flush busy", 64'(bus.busy), 64'd0);
        checkOutput("flush done", 64'(bus.done), 64'd0);
        checkOutput("flush result", 64'(bus.result), 64'hFFFFFFEB);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) done_seen++;
        end
        checkOutput("flush no done", 64'(done_seen), 64'd0);
        checkOutput("flush result kept", 64'(bus.result), 64'hFFFFFFEB);

        bus.funct3 = 3'b000;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd5;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checkOutput("flush+start busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) done_seen++;
        end
        checkOutput("flush+start no done", 64'(done_seen), 64'd0);
        checkOutput("flush+start result", 64'(bus.result), 64'hFFFFFFEB);

        bus.funct3 = 3'b000;
        bus.op_a   = 32'd7;
        bus.op_b   = 32'hFFFFFFFD;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        rst = 1'b0;
        tick();
        checkOutput("midop reset busy", 64'(bus.busy), 64'd0);
        checkOutput("midop reset done", 64'(bus.done), 64'd0);
        checkOutput("midop reset result", 64'(bus.result), 64'd0);
        rst = 1'b1;
        applyStimulus("mulhu after reset", 3'b011, 32'd3, 32'd3, 32'd0, 0);
        applyStimulus("mul after reset", 3'b000, 32'd3, 32'd3, 32'd9, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
